// File: rtl/adder_accumulator_pkg.sv
// Shared types and constants for the adder_accumulator slice.
// State encoding is fixed so the FSM can be probed consistently across builds.
package adder_accumulator_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Single-bit full adder returning {carry_out, sum}.
  function automatic logic [1:0] fullAdd(input logic a, input logic b, input logic c);
    logic s;
    logic co;
    s  = a ^ b ^ c;
    co = (a & b) | (a & c) | (b & c);
    return {co, s};
  endfunction

endpackage

// File: rtl/eight_bit_adder.sv
// Ripple-carry 8-bit adder datapath used by adder_accumulator.
// Purely combinational: so = a + b + ci, co is the carry out of bit 7.
module eight_bit_adder
  import adder_accumulator_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              ci,
  output logic [DATA_W-1:0] so,
  output logic              co
);

  logic [DATA_W:0] w_carry;

  assign w_carry[0] = ci;

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    assign {w_carry[i+1], so[i]} = fullAdd(a[i], b[i], w_carry[i]);
  end

  assign co = w_carry[DATA_W];

endmodule

// File: rtl/adder_accumulator.sv
// Multi-operand summation stage: folds len operands through eight_bit_adder, counts carries.
// Optional build macro ACC_ABORT_EN adds a synchronous i_abort input that cancels a run.
module adder_accumulator
  import adder_accumulator_pkg::*;
#(
  parameter int CNT_W = 4
) (
`ifdef ACC_ABORT_EN
  input  logic                    i_abort,
`endif
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [CNT_W-1:0]        i_len,
  input  logic                    i_in_valid,
  input  logic [DATA_W-1:0]       i_in_data,
  output logic                    o_in_ready,
  output logic                    o_out_valid,
  output logic [DATA_W+CNT_W-1:0] o_out_sum,
  input  logic                    i_out_ready,
  output logic                    o_busy
);

  state_t             r_state;
  state_t             w_nextState;
  logic [DATA_W-1:0]  r_acc;
  logic [CNT_W-1:0]   r_carryCnt;
  logic [CNT_W-1:0]   r_remaining;

  logic [DATA_W-1:0]  w_adderSum;
  logic               w_adderCo;
  logic               w_accept;
  logic               w_abort;

`ifdef ACC_ABORT_EN
  assign w_abort = i_abort && (r_state != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept = i_in_valid && (r_state == ACCUM);

  eight_bit_adder u_adder (
    .a  (r_acc),
    .b  (i_in_data),
    .ci (1'b0),
    .so (w_adderSum),
    .co (w_adderCo)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Abort outranks every other transition, including a same-cycle handshake.
  always_comb begin
    w_nextState = r_state;
    if (w_abort) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            w_nextState = (i_len == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (w_accept && (r_remaining == CNT_W'(1))) begin
            w_nextState = DONE;
          end
        end
        DONE: begin
          if (i_out_ready) begin
            w_nextState = IDLE;
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    o_in_ready  = (r_state == ACCUM);
    o_out_valid = (r_state == DONE);
    o_busy      = (r_state != IDLE);
    o_out_sum   = '0;
    if (r_state == DONE) begin
      o_out_sum = {r_carryCnt, r_acc};
    end
  end

  // The carry counter can never wrap: (2^CNT_W-1)*255 fits in DATA_W+CNT_W bits.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc       <= '0;
      r_carryCnt  <= '0;
      r_remaining <= '0;
    end else if (w_abort) begin
      r_acc       <= '0;
      r_carryCnt  <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_acc       <= '0;
            r_carryCnt  <= '0;
            r_remaining <= i_len;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_acc       <= w_adderSum;
            r_carryCnt  <= r_carryCnt + CNT_W'(w_adderCo);
            r_remaining <= r_remaining - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_accumulator.sv
// Directed self-checking bench for adder_accumulator (default build and ACC_ABORT_EN build).
// Each vector drives one clock cycle; outputs are checked 1 time unit after the rising edge.
module tb_adder_accumulator;

  localparam int CNT_W = 4;
  localparam int SUM_W = 8 + CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             inValid;
  logic [7:0]       inData;
  logic             inReady;
  logic             outValid;
  logic [SUM_W-1:0] outSum;
  logic             outReady;
  logic             busy;
`ifdef ACC_ABORT_EN
  logic             abort;
`endif

  int assertCount = 0;
  int failCount   = 0;

  adder_accumulator #(.CNT_W(CNT_W)) dut (
`ifdef ACC_ABORT_EN
    .i_abort     (abort),
`endif
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_len       (len),
    .i_in_valid  (inValid),
    .i_in_data   (inData),
    .o_in_ready  (inReady),
    .o_out_valid (outValid),
    .o_out_sum   (outSum),
    .i_out_ready (outReady),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, advance past the rising edge, then return inputs to idle.
  task automatic applyStimulus(input logic startIn, input logic [CNT_W-1:0] lenIn,
                               input logic validIn, input logic [7:0] dataIn,
                               input logic readyIn);
    start    = startIn;
    len      = lenIn;
    inValid  = validIn;
    inData   = dataIn;
    outReady = readyIn;
    @(posedge clk);
    #1;
    start    = 1'b0;
    len      = '0;
    inValid  = 1'b0;
    inData   = '0;
    outReady = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".in_ready"},  32'(inReady),  32'd0);
    checkOutput({tag, ".out_valid"}, 32'(outValid), 32'd0);
    checkOutput({tag, ".out_sum"},   32'(outSum),   32'd0);
    checkOutput({tag, ".busy"},      32'(busy),     32'd0);
  endtask

  task automatic takeResult(input string tag);
    applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b1);
    checkOutput({tag, ".idle_busy"},  32'(busy),     32'd0);
    checkOutput({tag, ".idle_valid"}, 32'(outValid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; inValid = 1'b0; inData = '0; outReady = 1'b0;
`ifdef ACC_ABORT_EN
    abort = 1'b0;
`endif
    #1;
    checkIdle("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Two small operands: 2 + 3 = 5, result one cycle after the second accept.
    applyStimulus(1'b1, 4'd2, 1'b0, 8'h00, 1'b0);
    checkOutput("run1.in_ready", 32'(inReady), 32'd1);
    checkOutput("run1.busy",     32'(busy),    32'd1);
    applyStimulus(1'b0, '0, 1'b1, 8'd2, 1'b0);
    checkOutput("run1.early_valid", 32'(outValid), 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 8'd3, 1'b0);
    checkOutput("run1.out_valid", 32'(outValid), 32'd1);
    checkOutput("run1.out_sum",   32'(outSum),   32'h005);
    checkOutput("run1.ready_off", 32'(inReady),  32'd0);
    takeResult("run1");

    // 255 + 1 wraps the low byte and produces one carry.
    applyStimulus(1'b1, 4'd2, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 8'd255, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 8'd1, 1'b0);
    checkOutput("run2.out_valid", 32'(outValid), 32'd1);
    checkOutput("run2.out_sum",   32'(outSum),   32'h100);
    takeResult("run2");

    // Fifteen operands of 255 with a gap after each one: 15*255 = 3825 = 0xEF1.
    applyStimulus(1'b1, 4'd15, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 8'd255, 1'b0);
      if (i < 14) begin
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
        checkOutput($sformatf("run3.gap%0d.in_ready", i), 32'(inReady), 32'd1);
      end
    end
    checkOutput("run3.out_valid", 32'(outValid), 32'd1);
    checkOutput("run3.out_sum",   32'(outSum),   32'(15 * 255));
    takeResult("run3");

    // Zero-length run goes straight to DONE and holds while the consumer stalls.
    applyStimulus(1'b1, 4'd0, 1'b0, 8'h00, 1'b0);
    checkOutput("run4.out_valid", 32'(outValid), 32'd1);
    checkOutput("run4.out_sum",   32'(outSum),   32'd0);
    checkOutput("run4.in_ready",  32'(inReady),  32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'd3, 1'b1, 8'h55, 1'b0);
      checkOutput($sformatf("run4.hold%0d.out_valid", i), 32'(outValid), 32'd1);
      checkOutput($sformatf("run4.hold%0d.out_sum", i),   32'(outSum),   32'd0);
      checkOutput($sformatf("run4.hold%0d.in_ready", i),  32'(inReady),  32'd0);
    end
    takeResult("run4");

    // Reset mid-run discards the partial sum; a fresh start is required afterwards.
    applyStimulus(1'b1, 4'd4, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 8'd10, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 8'd20, 1'b0);
    rst = 1'b1;
    #1;
    checkIdle("run5.reset");
    #2;
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b1, 8'd9, 1'b0);
    checkOutput("run5.no_start.busy",     32'(busy),    32'd0);
    checkOutput("run5.no_start.in_ready", 32'(inReady), 32'd0);
    applyStimulus(1'b1, 4'd1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 8'd7, 1'b0);
    checkOutput("run5.out_valid", 32'(outValid), 32'd1);
    checkOutput("run5.out_sum",   32'(outSum),   32'h007);
    takeResult("run5");

`ifdef ACC_ABORT_EN
    // Abort after one operand; the operand offered in the abort cycle is discarded.
    applyStimulus(1'b1, 4'd2, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 8'd9, 1'b0);
    abort = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, 8'd5, 1'b0);
    abort = 1'b0;
    checkOutput("run6.abort.busy",     32'(busy),     32'd0);
    checkOutput("run6.abort.in_ready", 32'(inReady),  32'd0);
    checkOutput("run6.abort.valid",    32'(outValid), 32'd0);
    applyStimulus(1'b1, 4'd1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 8'd4, 1'b0);
    checkOutput("run6.out_valid", 32'(outValid), 32'd1);
    checkOutput("run6.out_sum",   32'(outSum),   32'h004);
    takeResult("run6");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
